// File: rtl/seq_mult.sv
// Sequential shift-and-add multiplier, one multiplier bit per cycle.
// Ports: Clk, Rst (async high) | Start, Signed_Mode, A, B in | Busy, Done, P out.
module seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Start,
  input  logic               Signed_Mode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] P
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH:0]   acc;
  logic [CW-1:0]      cnt;
  logic               neg;

  logic [WIDTH-1:0]   amag;
  logic [WIDTH-1:0]   bmag;
  logic [WIDTH:0]     upper;
  logic [2*WIDTH:0]   acc_nx;
  logic [2*WIDTH-1:0] res;
  logic [2*WIDTH-1:0] res_nx;
  logic               load;
  logic               last;

  // Most negative input wraps to 2^(WIDTH-1), which is exactly the
  // unsigned magnitude we want.
  assign amag = (Signed_Mode && A[WIDTH-1]) ? -A : A;
  assign bmag = (Signed_Mode && B[WIDTH-1]) ? -B : B;

  assign load = Start && (state != RUN);
  assign last = (state == RUN) && (cnt == CW'(1));

  // Add and shift fused: carry lands in the top bit of the upper part
  // and is shifted down into the product in the same edge.
  assign upper  = acc[0] ? acc[2*WIDTH:WIDTH] + {1'b0, mcand}
                         : acc[2*WIDTH:WIDTH];
  assign acc_nx = {1'b0, upper, acc[WIDTH-1:1]};
  assign res    = acc_nx[2*WIDTH-1:0];
  assign res_nx = neg ? -res : res;

  assign Busy = (state == RUN);
  assign Done = (state == DONE);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (Start) state_nx = RUN;
      RUN:  if (last) state_nx = DONE;
      DONE: state_nx = Start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      P     <= '0;
    end else if (load) begin
      mcand <= amag;
      acc   <= {{(WIDTH + 1){1'b0}}, bmag};
      cnt   <= CW'(WIDTH);
      neg   <= Signed_Mode & (A[WIDTH-1] ^ B[WIDTH-1]);
    end else if (state == RUN) begin
      acc <= acc_nx;
      cnt <= cnt - CW'(1);
      if (last) P <= res_nx;
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// Scoreboard bench for seq_mult at WIDTH=8 and WIDTH=16.
// Stimulus pushes expected products; monitors pop on Done.
module tb_seq_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        st8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        st16, sm16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  logic [15:0] q8[$];
  logic [31:0] q16[$];
  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  seq_mult #(.WIDTH(8)) u8 (
    .Clk(clk), .Rst(rst), .Start(st8), .Signed_Mode(sm8),
    .A(a8), .B(b8), .Busy(busy8), .Done(done8), .P(p8)
  );

  seq_mult #(.WIDTH(16)) u16 (
    .Clk(clk), .Rst(rst), .Start(st16), .Signed_Mode(sm16),
    .A(a16), .B(b16), .Busy(busy16), .Done(done16), .P(p16)
  );

  always @(negedge clk) begin
    if (!rst && done8) begin
      logic [15:0] e;
      nvec++;
      if (busy8) begin
        nerr++;
        $display("FAIL excl8: Busy=1 with Done=1, required Busy=0");
      end
      if (q8.size() == 0) begin
        nerr++;
        $display("FAIL done8_unexpected: P=%h, required no Done", p8);
      end else begin
        e = q8.pop_front();
        if (p8 !== e) begin
          nerr++;
          $display("FAIL prod8: P=%h, required %h", p8, e);
        end
      end
    end
    if (!rst && done16) begin
      logic [31:0] e;
      nvec++;
      if (busy16) begin
        nerr++;
        $display("FAIL excl16: Busy=1 with Done=1, required Busy=0");
      end
      if (q16.size() == 0) begin
        nerr++;
        $display("FAIL done16_unexpected: P=%h, required no Done", p16);
      end else begin
        e = q16.pop_front();
        if (p16 !== e) begin
          nerr++;
          $display("FAIL prod16: P=%h, required %h", p16, e);
        end
      end
    end
  end

  task automatic launch8(input logic sm, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] e,
                         input logic push);
    st8 = 1'b1;
    sm8 = sm;
    a8  = a;
    b8  = b;
    if (push) q8.push_back(e);
  endtask

  // Called right after launch8; returns at the Done negedge.
  task automatic wait8(input int poke, input logic hchk,
                       input logic [15:0] hval);
    int lat = 0;
    int nb = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) st8 = 1'b0;
      if (i == poke) begin
        st8 = 1'b1;
        sm8 = 1'b1;
        a8  = 8'hFF;
        b8  = 8'h80;
      end
      if (i == poke + 1) st8 = 1'b0;
      if (busy8) nb++;
      if (hchk && busy8) begin
        nvec++;
        if (p8 !== hval) begin
          nerr++;
          $display("FAIL hold8: P=%h, required %h", p8, hval);
        end
      end
      if (done8) begin
        lat = i;
        break;
      end
    end
    nvec++;
    if (lat != 9 || nb != 8) begin
      nerr++;
      $display("FAIL timing8: done_edge=%0d busy=%0d, required 9 and 8",
               lat, nb);
    end
  endtask

  task automatic run8(input logic sm, input logic [7:0] a,
                      input logic [7:0] b, input logic [15:0] e,
                      input int poke);
    @(negedge clk);
    launch8(sm, a, b, e, 1'b1);
    wait8(poke, 1'b0, 16'h0);
  endtask

  task automatic run16(input logic sm, input logic [15:0] a,
                       input logic [15:0] b, input logic [31:0] e);
    int lat = 0;
    int nb = 0;
    @(negedge clk);
    st16 = 1'b1;
    sm16 = sm;
    a16  = a;
    b16  = b;
    q16.push_back(e);
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) st16 = 1'b0;
      if (busy16) nb++;
      if (done16) begin
        lat = i;
        break;
      end
    end
    nvec++;
    if (lat != 17 || nb != 16) begin
      nerr++;
      $display("FAIL timing16: done_edge=%0d busy=%0d, required 17 and 16",
               lat, nb);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    rst  = 1'b1;
    st8  = 1'b0;
    sm8  = 1'b0;
    a8   = '0;
    b8   = '0;
    st16 = 1'b0;
    sm16 = 1'b0;
    a16  = '0;
    b16  = '0;
    #2;
    nvec++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || p8 !== 16'h0) begin
      nerr++;
      $display("FAIL reset8: busy=%b done=%b P=%h, required 0 0 0000",
               busy8, done8, p8);
    end
    nvec++;
    if (busy16 !== 1'b0 || done16 !== 1'b0 || p16 !== 32'h0) begin
      nerr++;
      $display("FAIL reset16: busy=%b done=%b P=%h, required 0 0 0",
               busy16, done16, p16);
    end
    @(negedge clk);
    rst = 1'b0;

    run8(1'b0, 8'd13, 8'd11, 16'h008F, 0);
    run8(1'b0, 8'hFF, 8'hFF, 16'hFE01, 0);
    run8(1'b0, 8'hFD, 8'h05, 16'h04F1, 0);
    run8(1'b1, 8'hFD, 8'h05, 16'hFFF1, 0);
    run8(1'b1, 8'h80, 8'h80, 16'h4000, 0);
    run8(1'b1, 8'h00, 8'hF9, 16'h0000, 0);
    run8(1'b1, 8'h7F, 8'h80, 16'hC080, 0);
    run8(1'b0, 8'h80, 8'h02, 16'h0100, 0);
    run8(1'b0, 8'h12, 8'h34, 16'h03A8, 3);

    run8(1'b0, 8'd2, 8'd3, 16'd6, 0);
    launch8(1'b0, 8'd7, 8'd9, 16'd63, 1'b1);
    wait8(0, 1'b1, 16'd6);

    @(negedge clk);
    launch8(1'b0, 8'hC8, 8'h0B, 16'h0, 1'b0);
    @(negedge clk);
    st8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    nvec++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || p8 !== 16'h0) begin
      nerr++;
      $display("FAIL abort8: busy=%b done=%b P=%h, required 0 0 0000",
               busy8, done8, p8);
    end
    #1 rst = 1'b0;
    nd = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8) nd++;
    end
    nvec++;
    if (nd != 0) begin
      nerr++;
      $display("FAIL abort_done8: saw %0d Done, required 0", nd);
    end
    run8(1'b0, 8'd9, 8'd10, 16'h005A, 0);

    run16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    run16(1'b1, 16'h8000, 16'h0002, 32'hFFFF0000);

    repeat (3) @(negedge clk);
    nvec++;
    if (q8.size() != 0 || q16.size() != 0) begin
      nerr++;
      $display("FAIL drain: pending8=%0d pending16=%0d, required 0 0",
               q8.size(), q16.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
